// File: rtl/golden_nonce_fifo.sv
// rtl/golden_nonce_fifo.sv - captures miner golden nonces into a FIFO and serialises them to the host bytewise
module golden_nonce_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           golden_nonce,
  input  logic [31:0]           nonce2,
  input  logic [31:0]           hash2,
  input  logic                  wr_start,
  input  logic                  wr_clk,
  output logic [7:0]            write,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Capture history: the miner holds its last find, so a change is a new find.
  logic [31:0]           last_gn;

  // Circular buffer of {hash2, nonce2, golden_nonce} records.
  logic [95:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;

  // Host-side synchronisers.
  logic                  s1, s2, s3;
  logic [3:0]            b;

  // Record being shifted out to the host: status byte in the low byte.
  logic [103:0]          outbuf;

  logic                  cap;
  logic                  full;
  logic                  load;
  logic                  shift;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [95:0]           head_entry;
  logic [3:0]            cnt4;
  logic [7:0]            status;

  assign cap   = (golden_nonce != last_gn);
  assign full  = (fifo_count == DEPTH_CNT);
  assign load  = s2 & ~s3;
  assign shift = (b[3] == b[2]) & (b[2] == b[1]) & (b[1] != b[0]);

  // A load pops only when something is held; a full FIFO still accepts a
  // capture when the same cycle's pop frees the head slot.
  assign pop   = load & (fifo_count != '0);
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  // The head is read before the edge, so a same-slot push on a full FIFO is safe.
  assign head_entry = pop ? mem[rd_ptr] : 96'd0;
  assign cnt4       = 4'(fifo_count);
  assign status     = {overflow, 3'b000, cnt4};

  // Remember the last reported golden nonce for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gn <= 32'd0;
    end else begin
      last_gn <= golden_nonce;
    end
  end

  // Record storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {hash2, nonce2, golden_nonce};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky drop flag: a load reports and clears it unless a drop lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (load) begin
      overflow <= 1'b0;
    end
  end

  // Synchronise the host load request and its toggle-coded byte strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      b  <= 4'd0;
    end else begin
      s1 <= wr_start;
      s2 <= s1;
      s3 <= s2;
      b  <= {b[2:0], wr_clk};
    end
  end

  // Output shift register: a load replaces the record and beats a coincident shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outbuf <= 104'd0;
    end else if (load) begin
      outbuf <= {head_entry, status};
    end else if (shift) begin
      outbuf <= {8'h00, outbuf[103:8]};
    end
  end

  // Registered byte presented to the host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write <= 8'h00;
    end else begin
      write <= outbuf[7:0];
    end
  end

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// tb/tb_golden_nonce_fifo.sv - scoreboard bench for golden_nonce_fifo
module tb_golden_nonce_fifo;

  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;

  logic          clk;
  logic          reset;
  logic [31:0]   golden_nonce;
  logic [31:0]   nonce2;
  logic [31:0]   hash2;
  logic          wr_start;
  logic          wr_clk;
  logic [7:0]    write;
  logic [DL2:0]  fifo_count;
  logic          overflow;

  golden_nonce_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .reset        (reset),
    .golden_nonce (golden_nonce),
    .nonce2       (nonce2),
    .hash2        (hash2),
    .wr_start     (wr_start),
    .wr_clk       (wr_clk),
    .write        (write),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] wb;
    int         cnt;
    bit         ovf;
    int         id;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           chk_id = 0;
  logic         chk = 1'b0;

  // Reference model: a queue of captured records plus the host-visible record.
  logic [95:0]  mq[$];
  bit           m_ovf;
  logic [103:0] m_rec;
  int           m_idx;

  function automatic logic [7:0] m_byte();
    logic [103:0] r;
    if (m_idx > 12) return 8'h00;
    r = m_rec >> (8 * m_idx);
    return r[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_cap();
    if (mq.size() < DEPTH) mq.push_back({hash2, nonce2, golden_nonce});
    else m_ovf = 1'b1;
  endtask

  task automatic model_load();
    logic [95:0] e;
    logic [7:0]  st;
    st = {m_ovf, 3'b000, 4'(mq.size())};
    if (mq.size() > 0) e = mq.pop_front();
    else e = 96'd0;
    m_ovf = 1'b0;
    m_rec = {e, st};
    m_idx = 0;
  endtask

  task automatic check_now();
    exp_t e;
    e.wb  = m_byte();
    e.cnt = mq.size();
    e.ovf = m_ovf;
    e.id  = chk_id;
    chk_id++;
    exp_q.push_back(e);
    chk = 1'b1;
    step();
    chk = 1'b0;
  endtask

  task automatic set_new();
    logic [31:0] g;
    g = $urandom;
    if (g == golden_nonce) g = g ^ 32'd1;
    golden_nonce = g;
    nonce2       = $urandom;
    hash2        = $urandom;
  endtask

  task automatic do_cap(input logic [31:0] g, input logic [31:0] n, input logic [31:0] h);
    golden_nonce = g;
    nonce2       = n;
    hash2        = h;
    step();
    model_cap();
  endtask

  task automatic cap_rand();
    set_new();
    step();
    model_cap();
  endtask

  task automatic read_byte();
    wr_clk = ~wr_clk;
    step();
    step();
    step();
    m_idx++;
    check_now();
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) read_byte();
  endtask

  task automatic do_load(input bit with_cap, input bit with_tog, input bit hold);
    wr_start = 1'b1;
    step();
    if (with_tog) wr_clk = ~wr_clk;
    step();
    if (with_cap) set_new();
    step();
    model_load();
    if (with_cap) model_cap();
    if (!hold) wr_start = 1'b0;
    step();
    check_now();
  endtask

  task automatic reset_mid();
    reset        = 1'b1;
    golden_nonce = 32'd0;
    nonce2       = 32'd0;
    hash2        = 32'd0;
    mq.delete();
    m_ovf = 1'b0;
    m_rec = 104'd0;
    m_idx = 0;
    #1;
    check_now();
    reset = 1'b0;
    step();
    check_now();
    repeat (4) step();
  endtask

  // Monitor: compares every sampled output against the oldest expectation.
  always @(negedge clk) begin
    if (chk) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: sample requested, got no expectation, required one");
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (write !== e.wb) begin
          fails++;
          $display("FAIL chk%0d write: got 0x%02h, required 0x%02h", e.id, write, e.wb);
        end
        tests++;
        if (fifo_count !== 4'(e.cnt)) begin
          fails++;
          $display("FAIL chk%0d fifo_count: got %0d, required %0d", e.id, fifo_count, e.cnt);
        end
        tests++;
        if (overflow !== e.ovf) begin
          fails++;
          $display("FAIL chk%0d overflow: got %0b, required %0b", e.id, overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int r;
    reset        = 1'b1;
    golden_nonce = 32'd0;
    nonce2       = 32'd0;
    hash2        = 32'd0;
    wr_start     = 1'b0;
    wr_clk       = 1'b0;
    m_ovf        = 1'b0;
    m_rec        = 104'd0;
    m_idx        = 0;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();

    // Reset state and an empty load: status 0x00 then twelve zero bytes.
    check_now();
    do_load(1'b0, 1'b0, 1'b0);
    read_n(12);

    // Single capture read back byte by byte.
    do_cap(32'h12345678, 32'hAABBCCDD, 32'h00000000);
    check_now();
    do_load(1'b0, 1'b0, 1'b0);
    read_n(12);
    check_now();

    // Nine distinct finds with no reads: full plus a dropped entry.
    for (int i = 0; i < 9; i++) do_cap(32'h1000 + i, $urandom, $urandom);
    check_now();

    // Load while full with a capture landing on the load cycle, then drain all.
    do_load(1'b1, 1'b0, 1'b0);
    read_n(12);
    for (int k = 0; k < DEPTH; k++) begin
      do_load(1'b0, 1'b0, 1'b0);
      read_n(12);
    end
    do_load(1'b0, 1'b0, 1'b0);

    // Load and byte strobe toggle on the same cycle.
    cap_rand();
    do_load(1'b0, 1'b1, 1'b0);
    read_n(12);

    // Held wr_start yields exactly one load.
    cap_rand();
    cap_rand();
    do_load(1'b0, 1'b0, 1'b1);
    repeat (10) step();
    check_now();
    wr_start = 1'b0;
    repeat (3) step();
    do_load(1'b0, 1'b0, 1'b0);
    read_n(12);

    // Reset in the middle of a readout.
    cap_rand();
    do_load(1'b0, 1'b0, 1'b0);
    read_n(5);
    reset_mid();
    do_load(1'b0, 1'b0, 1'b0);
    read_n(12);

    // Randomised mix of captures, loads (with coincident events) and reads.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        cap_rand();
      end else if (r <= 7) begin
        do_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        read_n($urandom_range(0, 14));
      end else if (r == 8) begin
        check_now();
      end else begin
        read_byte();
      end
    end
    check_now();

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
